// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing around ID and EX operand forwarding selects; outputs are 0-cycle combinational.
// dmem_busy_i freezes the whole pipe and the FSM; build with HAZARD_PERF_CNT_EN for saturating event counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [4:0]       rs1D_idx_i,
  input  logic [4:0]       rs2D_idx_i,
  input  logic [4:0]       rs1E_idx_i,
  input  logic [4:0]       rs2E_idx_i,
  input  logic [4:0]       rdE_addr_i,
  input  logic             rdE_wrt_ena_i,
  input  logic             loadE_i,
  input  logic [4:0]       rdM_addr_i,
  input  logic             rdM_wrt_ena_i,
  input  logic [4:0]       rdW_addr_i,
  input  logic             rdW_wrt_ena_i,
  input  logic             redirectE_i,
  input  logic             dmem_busy_i,
  output logic             stallF_o,
  output logic             stallD_o,
  output logic             stallE_o,
  output logic             stallM_o,
  output logic             flushD_o,
  output logic             flushE_o,
  output logic [1:0]       fwdA_o,
  output logic [1:0]       fwdB_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] busy_cnt_o
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_e;

  localparam logic [2:0] LU_CNT_INIT = 3'(LOAD_STALL_CYC - 1);
  localparam bit         LU_MULTI    = (LOAD_STALL_CYC > 1);

  if (LOAD_STALL_CYC == 0 || LOAD_STALL_CYC > 7 || CNT_W == 0) begin : g_bad_param
    $error("hazard_ctrl: LOAD_STALL_CYC must be 1..7 and CNT_W nonzero");
  end

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu_hit;

  always_comb begin
    lu_hit = loadE_i && rdE_wrt_ena_i && (rdE_addr_i != 5'd0) &&
             ((rdE_addr_i == rs1D_idx_i) || (rdE_addr_i == rs2D_idx_i));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stallF_o = 1'b0;
    stallD_o = 1'b0;
    stallE_o = 1'b0;
    stallM_o = 1'b0;
    flushD_o = 1'b0;
    flushE_o = 1'b0;
    if (dmem_busy_i) begin
      // Whole pipe frozen; a pending redirect stays in EX and is acted on once busy drops.
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      stallE_o = 1'b1;
      stallM_o = 1'b1;
    end else if (redirectE_i) begin
      // The dependent instruction in ID is squashed, so any load-use wait is moot.
      flushD_o = 1'b1;
      flushE_o = 1'b1;
      state_d  = RUN;
      cnt_d    = 3'd0;
    end else if (state_q == LU_STALL) begin
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      flushE_o = 1'b1;
      cnt_d    = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = RUN;
      end
    end else if (lu_hit) begin
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      flushE_o = 1'b1;
      if (LU_MULTI) begin
        state_d = LU_STALL;
        cnt_d   = LU_CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM result is newer than WB, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    fwdA_o = 2'b00;
    fwdB_o = 2'b00;
    if (rdM_wrt_ena_i && (rdM_addr_i != 5'd0) && (rdM_addr_i == rs1E_idx_i)) begin
      fwdA_o = 2'b10;
    end else if (rdW_wrt_ena_i && (rdW_addr_i != 5'd0) && (rdW_addr_i == rs1E_idx_i)) begin
      fwdA_o = 2'b01;
    end
    if (rdM_wrt_ena_i && (rdM_addr_i != 5'd0) && (rdM_addr_i == rs2E_idx_i)) begin
      fwdB_o = 2'b10;
    end else if (rdW_wrt_ena_i && (rdW_addr_i != 5'd0) && (rdW_addr_i == rs2E_idx_i)) begin
      fwdB_o = 2'b01;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             lu_evt, rdr_evt;
  logic [CNT_W-1:0] lu_stall_cnt_q, lu_stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    lu_evt  = !dmem_busy_i && !redirectE_i && ((state_q == LU_STALL) || lu_hit);
    rdr_evt = !dmem_busy_i && redirectE_i;
    lu_stall_cnt_d = lu_stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    busy_cnt_d     = busy_cnt_q;
    if (lu_evt && (lu_stall_cnt_q != '1)) lu_stall_cnt_d = lu_stall_cnt_q + 1'b1;
    if (rdr_evt && (flush_cnt_q != '1))   flush_cnt_d    = flush_cnt_q + 1'b1;
    if (dmem_busy_i && (busy_cnt_q != '1)) busy_cnt_d    = busy_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lu_stall_cnt_q <= '0;
      flush_cnt_q    <= '0;
      busy_cnt_q     <= '0;
    end else begin
      lu_stall_cnt_q <= lu_stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      busy_cnt_q     <= busy_cnt_d;
    end
  end

  assign lu_stall_cnt_o = lu_stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;
  assign busy_cnt_o     = busy_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_STALL_CYC=1 and 3) share directed stimulus; a negedge monitor checks a scoreboard.
module tb_hazard_ctrl;

  localparam int CW = 32;

  logic clk;
  logic rstn;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic rdE_we, loadE, rdM_we, rdW_we, redirect, busy;

  logic sF1, sD1, sE1, sM1, fD1, fE1;
  logic sF3, sD3, sE3, sM3, fD3, fE3;
  logic [1:0] fA1, fB1, fA3, fB3;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] luc1, flc1, bsc1, luc3, flc3, bsc3;
`endif

  hazard_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(CW)) dut1 (
    .clk_i(clk), .rstn_i(rstn),
    .rs1D_idx_i(rs1D), .rs2D_idx_i(rs2D), .rs1E_idx_i(rs1E), .rs2E_idx_i(rs2E),
    .rdE_addr_i(rdE), .rdE_wrt_ena_i(rdE_we), .loadE_i(loadE),
    .rdM_addr_i(rdM), .rdM_wrt_ena_i(rdM_we), .rdW_addr_i(rdW), .rdW_wrt_ena_i(rdW_we),
    .redirectE_i(redirect), .dmem_busy_i(busy),
    .stallF_o(sF1), .stallD_o(sD1), .stallE_o(sE1), .stallM_o(sM1),
    .flushD_o(fD1), .flushE_o(fE1), .fwdA_o(fA1), .fwdB_o(fB1)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cnt_o(luc1), .flush_cnt_o(flc1), .busy_cnt_o(bsc1)
`endif
  );

  hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(CW)) dut3 (
    .clk_i(clk), .rstn_i(rstn),
    .rs1D_idx_i(rs1D), .rs2D_idx_i(rs2D), .rs1E_idx_i(rs1E), .rs2E_idx_i(rs2E),
    .rdE_addr_i(rdE), .rdE_wrt_ena_i(rdE_we), .loadE_i(loadE),
    .rdM_addr_i(rdM), .rdM_wrt_ena_i(rdM_we), .rdW_addr_i(rdW), .rdW_wrt_ena_i(rdW_we),
    .redirectE_i(redirect), .dmem_busy_i(busy),
    .stallF_o(sF3), .stallD_o(sD3), .stallE_o(sE3), .stallM_o(sM3),
    .flushD_o(fD3), .flushE_o(fE3), .fwdA_o(fA3), .fwdB_o(fB3)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cnt_o(luc3), .flush_cnt_o(flc3), .busy_cnt_o(bsc3)
`endif
  );

  // Expected vector: {stallF, stallD, stallE, stallM, flushD, flushE, fwdA, fwdB}
  localparam logic [9:0] NONE = 10'b0000_00_00_00;
  localparam logic [9:0] LU   = 10'b1100_01_00_00;
  localparam logic [9:0] BSY  = 10'b1111_00_00_00;
  localparam logic [9:0] RDR  = 10'b0000_11_00_00;

  typedef struct {
    string      nm;
    logic [9:0] e1;
    logic [9:0] e3;
    bit         chk3;
    bit         chk_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    exp_t e;
    logic [9:0] a1, a3;
    a1 = {sF1, sD1, sE1, sM1, fD1, fE1, fA1, fB1};
    a3 = {sF3, sD3, sE3, sM3, fD3, fE3, fA3, fB3};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a1 !== e.e1) begin
        errors++;
        $display("FAIL %s dut1 got %b want %b", e.nm, a1, e.e1);
      end
      if (e.chk3) begin
        checks++;
        if (a3 !== e.e3) begin
          errors++;
          $display("FAIL %s dut3 got %b want %b", e.nm, a3, e.e3);
        end
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e.chk_cnt) begin
        checks++;
        if ({luc1, flc1, bsc1, luc3, flc3, bsc3} !== '0) begin
          errors++;
          $display("FAIL %s counters got %0d %0d %0d %0d %0d %0d want all 0",
                   e.nm, luc1, flc1, bsc1, luc3, flc3, bsc3);
        end
      end
`endif
      checks++;
      if ((fD1 && sD1) || (sE1 && !sD1) || (fD3 && sD3) || (sE3 && !sD3)) begin
        errors++;
        $display("FAIL %s invariant dut1 fD/sD/sE=%b%b%b dut3=%b%b%b want flushD->!stallD, stallE->stallD",
                 e.nm, fD1, sD1, sE1, fD3, sD3, sE3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
    rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
    rdE_we = 1'b0; loadE = 1'b0; rdM_we = 1'b0; rdW_we = 1'b0;
    redirect = 1'b0; busy = 1'b0;
  endtask

  task automatic expect_cyc(input string nm, input logic [9:0] e1, input logic [9:0] e3,
                            input bit chk3 = 1'b1, input bit chk_cnt = 1'b0);
    exp_t e;
    e.nm = nm; e.e1 = e1; e.e3 = e3; e.chk3 = chk3; e.chk_cnt = chk_cnt;
    exp_q.push_back(e);
  endtask

  task automatic lw_x5_dep();
    loadE = 1'b1; rdE_we = 1'b1; rdE = 5'd5; rs1D = 5'd5;
  endtask

  initial begin
    rstn = 1'b0;
    clr();
    tick(); expect_cyc("reset", NONE, NONE, 1'b1, 1'b1);

    // Load-use, rs1 dependency; bubble removes the hazard from EX afterwards
    tick(); rstn = 1'b1; lw_x5_dep(); expect_cyc("lu_c1", LU, LU);
    tick(); clr(); expect_cyc("lu_c2", NONE, LU);
    tick(); clr(); expect_cyc("lu_c3", NONE, LU);
    tick(); clr(); expect_cyc("lu_done", NONE, NONE);
    tick(); clr(); loadE = 1'b1; rdE_we = 1'b1; rdE = 5'd0; expect_cyc("lu_x0", NONE, NONE);
    tick(); clr(); loadE = 1'b1; rdE = 5'd5; rs1D = 5'd5; expect_cyc("lu_no_we", NONE, NONE);
    tick(); clr(); rdE_we = 1'b1; rdE = 5'd5; rs1D = 5'd5; expect_cyc("not_load", NONE, NONE);

    // rs2 dependency, then redirect while dut3 sits in LU_STALL with cnt=2
    tick(); clr(); loadE = 1'b1; rdE_we = 1'b1; rdE = 5'd9; rs1D = 5'd3; rs2D = 5'd9;
    expect_cyc("lu_rs2", LU, LU);
    tick(); clr(); redirect = 1'b1; expect_cyc("rdr_in_lu", RDR, RDR);
    tick(); clr(); expect_cyc("rdr_after", NONE, NONE);

    // Redirect beats a simultaneous load-use hit
    tick(); clr(); lw_x5_dep(); redirect = 1'b1; expect_cyc("rdr_vs_lu", RDR, RDR);
    tick(); clr(); expect_cyc("rdr_vs_lu_nxt", NONE, NONE);

    // Busy with redirect held: four freeze cycles, then the redirect lands
    for (int i = 0; i < 4; i++) begin
      tick(); clr(); busy = 1'b1; redirect = 1'b1; expect_cyc($sformatf("busy_rdr%0d", i), BSY, BSY);
    end
    tick(); clr(); redirect = 1'b1; expect_cyc("busy_drop_rdr", RDR, RDR);
    tick(); clr(); expect_cyc("busy_rdr_done", NONE, NONE);

    // Busy holds LU_STALL count
    tick(); clr(); lw_x5_dep(); expect_cyc("lu_b1", LU, LU);
    tick(); clr(); busy = 1'b1; expect_cyc("lu_busy", BSY, BSY);
    tick(); clr(); expect_cyc("lu_b2", NONE, LU);
    tick(); clr(); expect_cyc("lu_b3", NONE, LU);
    tick(); clr(); expect_cyc("lu_b_done", NONE, NONE);

    // Busy beats a load-use hit and no LU_STALL is entered
    tick(); clr(); lw_x5_dep(); busy = 1'b1; expect_cyc("busy_vs_lu", BSY, BSY);
    tick(); clr(); expect_cyc("busy_vs_lu_nxt", NONE, NONE);

    // Forwarding
    tick(); clr(); rs1E = 5'd7; rdM = 5'd7; rdM_we = 1'b1; rdW = 5'd7; rdW_we = 1'b1;
    expect_cyc("fwd_mem_pri", 10'b0000_00_10_00, 10'b0000_00_10_00);
    tick(); rdM_we = 1'b0; expect_cyc("fwd_wb", 10'b0000_00_01_00, 10'b0000_00_01_00);
    tick(); clr(); rdM_we = 1'b1; rdW_we = 1'b1; expect_cyc("fwd_x0", NONE, NONE);
    tick(); clr(); rs1E = 5'd3; rs2E = 5'd12; rdM = 5'd12; rdM_we = 1'b1; rdW = 5'd3; rdW_we = 1'b1;
    expect_cyc("fwd_mixed", 10'b0000_00_01_10, 10'b0000_00_01_10);
    tick(); clr(); rs1E = 5'd4; rs2E = 5'd4; rdM = 5'd4; rdW = 5'd4; rdW_we = 1'b1;
    expect_cyc("fwd_both_wb", 10'b0000_00_01_01, 10'b0000_00_01_01);
    tick(); clr(); busy = 1'b1; rs1E = 5'd7; rdM = 5'd7; rdM_we = 1'b1;
    expect_cyc("fwd_in_busy", 10'b1111_00_10_00, 10'b1111_00_10_00);

    // Reset mid-LU_STALL (dut3 cnt=2); dut3 outputs while reset is low still reflect LU_STALL
    tick(); clr(); lw_x5_dep(); expect_cyc("lu_r1", LU, LU);
    tick(); clr(); rstn = 1'b0; expect_cyc("rst_mid_lu", NONE, LU, 1'b0);
    tick(); rstn = 1'b1; expect_cyc("post_rst", NONE, NONE, 1'b1, 1'b1);

    // Full sequence again from fresh state
    tick(); lw_x5_dep(); expect_cyc("lu_again1", LU, LU);
    tick(); clr(); expect_cyc("lu_again2", NONE, LU);
    tick(); clr(); expect_cyc("lu_again3", NONE, LU);
    tick(); clr(); expect_cyc("lu_again_done", NONE, NONE);

    stim_done = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
